// File: rtl/fixed_point_display_driver_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fixed_point_display_driver_if : request/result and display bus    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface fixed_point_display_driver_if;
  logic        start;
  logic [15:0] value;
  logic        busy;
  logic        done;
  logic        neg;
  logic [3:0]  bcd_hund;
  logic [3:0]  bcd_tens;
  logic [3:0]  bcd_ones;
  logic [3:0]  bcd_tenth;
  logic [3:0]  bcd_hundth;
  logic [5:0]  an;
  logic [6:0]  seg;
  logic        dp;

  modport master (
    output start, value,
    input  busy, done, neg, bcd_hund, bcd_tens, bcd_ones, bcd_tenth, bcd_hundth,
    input  an, seg, dp
  );

  modport slave (
    input  start, value,
    output busy, done, neg, bcd_hund, bcd_tens, bcd_ones, bcd_tenth, bcd_hundth,
    output an, seg, dp
  );
endinterface
`default_nettype wire

// File: rtl/fixed_point_display_driver.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fixed_point_display_driver : Q1.9.6 -> signed BCD + 7-seg scanner |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module fixed_point_display_driver #(
  parameter int SCAN_DIV = 50000
) (
  input logic                         clk,
  input logic                         rst_n,
  fixed_point_display_driver_if.slave bus
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state;
  logic [15:0] value_q;
  logic        neg_work;
  logic [9:0]  int_sh;
  logic [9:0]  frac_sh;
  logic [11:0] acc_int;
  logic [7:0]  acc_frac;
  logic [3:0]  shift_cnt;
  logic        busy_q;
  logic        done_q;
  logic        neg_q;
  logic [3:0]  hund_q, tens_q, ones_q, tenth_q, hundth_q;

  logic [CNT_W-1:0] scan_cnt;
  logic [2:0]       scan_idx;
  logic [2:0]       idx_next;
  logic             scan_wrap;
  logic [5:0]       an_q;
  logic [6:0]       seg_q;
  logic             dp_q;
  logic [6:0]       seg_next;
  logic             dp_next;

  logic [15:0] mag;
  logic [6:0]  fracd;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  assign mag   = value_q[15] ? (~value_q + 16'd1) : value_q;
  assign fracd = 7'((13'(mag[5:0]) * 13'd100 + 13'd32) >> 6);

  // Top nibbles stay below 5 until the final shift (hundreds <= 2, frac tens <= 4),
  // so only the lower nibbles need the +3 correction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      value_q   <= '0;
      neg_work  <= 1'b0;
      int_sh    <= '0;
      frac_sh   <= '0;
      acc_int   <= '0;
      acc_frac  <= '0;
      shift_cnt <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      neg_q     <= 1'b0;
      hund_q    <= '0;
      tens_q    <= '0;
      ones_q    <= '0;
      tenth_q   <= '0;
      hundth_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            value_q <= bus.value;
            busy_q  <= 1'b1;
            state   <= LOAD;
          end
        end
        LOAD: begin
          neg_work  <= value_q[15];
          int_sh    <= mag[15:6];
          frac_sh   <= {3'b000, fracd};
          acc_int   <= '0;
          acc_frac  <= '0;
          shift_cnt <= '0;
          state     <= SHIFT;
        end
        SHIFT: begin
          acc_int   <= {acc_int[10:8], add3(acc_int[7:4]), add3(acc_int[3:0]), int_sh[9]};
          acc_frac  <= {acc_frac[6:4], add3(acc_frac[3:0]), frac_sh[9]};
          int_sh    <= {int_sh[8:0], 1'b0};
          frac_sh   <= {frac_sh[8:0], 1'b0};
          shift_cnt <= shift_cnt + 4'd1;
          if (shift_cnt == 4'd9) state <= DONE;
        end
        DONE: begin
          hund_q   <= acc_int[11:8];
          tens_q   <= acc_int[7:4];
          ones_q   <= acc_int[3:0];
          tenth_q  <= acc_frac[7:4];
          hundth_q <= acc_frac[3:0];
          neg_q    <= neg_work;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign scan_wrap = (scan_cnt == CNT_W'(SCAN_DIV - 1));
  assign idx_next  = (scan_idx == 3'd5) ? 3'd0 : scan_idx + 3'd1;

  always_comb begin
    seg_next = 7'b1111111;
    dp_next  = 1'b1;
    case (idx_next)
      3'd0: seg_next = neg_q ? 7'b0111111 : 7'b1111111;
      3'd1: if (hund_q != 4'd0) seg_next = glyph(hund_q);
      3'd2: if (hund_q != 4'd0 || tens_q != 4'd0) seg_next = glyph(tens_q);
      3'd3: begin
        seg_next = glyph(ones_q);
        dp_next  = 1'b0;
      end
      3'd4: seg_next = glyph(tenth_q);
      3'd5: seg_next = glyph(hundth_q);
      default: seg_next = 7'b1111111;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      scan_idx <= '0;
      an_q     <= 6'b111110;
      seg_q    <= 7'b1111111;
      dp_q     <= 1'b1;
    end else if (scan_wrap) begin
      scan_cnt <= '0;
      scan_idx <= idx_next;
      an_q     <= ~(6'd1 << idx_next);
      seg_q    <= seg_next;
      dp_q     <= dp_next;
    end else begin
      scan_cnt <= scan_cnt + CNT_W'(1);
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.neg        = neg_q;
  assign bus.bcd_hund   = hund_q;
  assign bus.bcd_tens   = tens_q;
  assign bus.bcd_ones   = ones_q;
  assign bus.bcd_tenth  = tenth_q;
  assign bus.bcd_hundth = hundth_q;
  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;

endmodule
`default_nettype wire

// File: tb/tb_fixed_point_display_driver.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_fixed_point_display_driver : random + directed scoreboard bench|
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_fixed_point_display_driver;

  localparam int SCAN_DIV = 2;
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] GLYPH [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                        7'b0000000, 7'b0010000};
  localparam logic [15:0] DIRECTED [9] = '{16'h0240, 16'h00E0, 16'hFF70, 16'h8000, 16'h7FFF,
                                           16'h0001, 16'h0000, 16'hFFFF, 16'hE0A0};

  typedef struct {
    logic       neg;
    logic [3:0] h, t, o, te, hu;
    int         due;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   act_k    = -100;
  int   scan_base = 0;
  int   pub_cyc   = 0;
  exp_t q[$];
  exp_t shown;

  fixed_point_display_driver_if bus();

  fixed_point_display_driver #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain decimal arithmetic on the real value.
  function automatic exp_t model(input logic [15:0] v, input int due);
    exp_t e;
    int mag, ip, fp;
    mag   = v[15] ? (65536 - int'(v)) : int'(v);
    ip    = mag / 64;
    fp    = ((mag % 64) * 100 + 32) / 64;
    e.neg = v[15];
    e.h   = 4'(ip / 100);
    e.t   = 4'((ip / 10) % 10);
    e.o   = 4'(ip % 10);
    e.te  = 4'(fp / 10);
    e.hu  = 4'(fp % 10);
    e.due = due;
    return e;
  endfunction

  function automatic logic [6:0] exp_seg(input int p, input exp_t s);
    case (p)
      0:       return s.neg ? 7'b0111111 : BLANK;
      1:       return (s.h == 0) ? BLANK : GLYPH[int'(s.h)];
      2:       return (s.h == 0 && s.t == 0) ? BLANK : GLYPH[int'(s.t)];
      3:       return GLYPH[int'(s.o)];
      4:       return GLYPH[int'(s.te)];
      default: return GLYPH[int'(s.hu)];
    endcase
  endfunction

  // Monitor: pops the scoreboard on done, checks busy window and the scan.
  always @(negedge clk) begin
    if (rst_n) begin
      int         idx;
      logic [5:0] an_exp;
      logic       busy_exp;
      exp_t       e;
      if (bus.done) begin
        if (q.size() == 0) begin
          check("unexpected_done", 32'(bus.done), 32'd0);
        end else begin
          e = q.pop_front();
          check("done_latency", cyc, e.due);
          check("neg", 32'(bus.neg), 32'(e.neg));
          check("bcd_hund", 32'(bus.bcd_hund), 32'(e.h));
          check("bcd_tens", 32'(bus.bcd_tens), 32'(e.t));
          check("bcd_ones", 32'(bus.bcd_ones), 32'(e.o));
          check("bcd_tenth", 32'(bus.bcd_tenth), 32'(e.te));
          check("bcd_hundth", 32'(bus.bcd_hundth), 32'(e.hu));
          shown   = e;
          pub_cyc = cyc;
        end
      end
      busy_exp = (act_k >= 0) && (cyc >= act_k + 1) && (cyc <= act_k + 12);
      check("busy", 32'(bus.busy), 32'(busy_exp));
      idx    = ((cyc - scan_base) / SCAN_DIV) % 6;
      an_exp = ~(6'd1 << idx);
      check("an", 32'(bus.an), 32'(an_exp));
      if (cyc - pub_cyc >= SCAN_DIV) begin
        check("seg", 32'(bus.seg), 32'(exp_seg(idx, shown)));
        check("dp", 32'(bus.dp), (idx == 3) ? 32'd0 : 32'd1);
      end
    end
  end

  task automatic check_reset_state();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_neg", 32'(bus.neg), 32'd0);
    check("rst_digits", {12'd0, bus.bcd_hund, bus.bcd_tens, bus.bcd_ones, bus.bcd_tenth, bus.bcd_hundth}, 32'd0);
    check("rst_an", 32'(bus.an), 32'h3E);
    check("rst_seg", 32'(bus.seg), 32'h7F);
    check("rst_dp", 32'(bus.dp), 32'd1);
  endtask

  task automatic release_reset();
    @(negedge clk);
    scan_base = cyc;
    pub_cyc   = cyc;
    shown     = model(16'h0000, 0);
    act_k     = -100;
    rst_n     = 1'b1;
  endtask

  task automatic convert(input logic [15:0] v, input bit repulse, input int gap);
    int k;
    @(negedge clk);
    k         = cyc;
    bus.start = 1'b1;
    bus.value = v;
    q.push_back(model(v, k + 13));
    act_k = k;
    @(negedge clk);
    bus.start = 1'b0;
    bus.value = 16'($urandom);
    if (repulse) begin
      while (cyc < k + 3) @(negedge clk);
      bus.start = 1'b1;
      bus.value = 16'($urandom);
      @(negedge clk);
      bus.start = 1'b0;
      while (cyc < k + 7) @(negedge clk);
      bus.start = 1'b1;
      bus.value = 16'($urandom);
      @(negedge clk);
      bus.start = 1'b0;
    end
    while (cyc < k + 12 + gap) @(negedge clk);
  endtask

  task automatic abort_conversion(input logic [15:0] v);
    int k;
    @(negedge clk);
    k         = cyc;
    bus.start = 1'b1;
    bus.value = v;
    act_k     = k;
    @(negedge clk);
    bus.start = 1'b0;
    while (cyc < k + 6) @(negedge clk);
    act_k = -100;
    rst_n = 1'b0;
    #1;
    check_reset_state();
    repeat (2) @(negedge clk);
    release_reset();
  endtask

  initial begin
    bus.start = 1'b0;
    bus.value = 16'h0000;
    repeat (3) @(negedge clk);
    #1;
    check_reset_state();
    release_reset();
    repeat (14) @(negedge clk);

    foreach (DIRECTED[i]) convert(DIRECTED[i], 1'b0, 2);
    convert(16'h00E0, 1'b1, 0);
    abort_conversion(16'h0240);
    repeat (20) @(negedge clk);
    convert(16'hE0A0, 1'b0, 14);
    for (int i = 0; i < 40; i++) begin
      convert(16'($urandom), ($urandom_range(0, 3) == 0), int'($urandom_range(0, 4)));
    end
    convert(16'h0240, 1'b0, 16);

    for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge clk);
    check("scoreboard_drained", q.size(), 32'd0);
    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
